// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard command sequencer and scan-code decoder:
// FSM states, command/response bytes, Set-2 prefixes and the game-key codes.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SEND,
    ST_DROP,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_IDLE,
    ST_FAIL
  } kbd_state_t;

  // Which command byte is in flight; decides where an ACK leads.
  typedef enum logic [1:0] {
    CMD_RESET,
    CMD_LED,
    CMD_ARG
  } cmd_kind_t;

  localparam logic [7:0] CMD_RESET_KBD = 8'hFF;
  localparam logic [7:0] CMD_SET_LED   = 8'hED;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] RSP_ECHO      = 8'hEE;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_DROP   = 8'h29;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard housekeeping bytes that must never surface as key events.
  function automatic logic is_dropped_byte(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_BAT_OK) || (b == RSP_ECHO) ||
           (b == RSP_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: E0/F0 prefix tracking, Pause-sequence skipping,
// one-cycle key events and held levels for the game keys. Active only while idle=1.
module ps2_scan_decoder
  import ps2_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop
);

  logic       ext_flag;
  logic       brk_flag;
  logic [2:0] skip_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      skip_cnt   <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_down   <= 1'b0;
      key_rotate <= 1'b0;
      key_drop   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (idle && data_en) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (data == PFX_EXT) begin
          ext_flag <= 1'b1;
        end else if (data == PFX_BREAK) begin
          brk_flag <= 1'b1;
        end else if (data == PFX_PAUSE) begin
          skip_cnt <= PAUSE_SKIP;
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else if (is_dropped_byte(data)) begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          key_valid <= 1'b1;
          key_code  <= data;
          key_ext   <= ext_flag;
          key_break <= brk_flag;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
          // Arrow keys live behind E0; the drop key is the plain (non-E0) code only.
          if (ext_flag) begin
            case (data)
              SC_LEFT:   key_left   <= !brk_flag;
              SC_RIGHT:  key_right  <= !brk_flag;
              SC_DOWN:   key_down   <= !brk_flag;
              SC_ROTATE: key_rotate <= !brk_flag;
              default: ;
            endcase
          end else if (data == SC_DROP) begin
            key_drop <= !brk_flag;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// Command sequencer above PS2_Controller: keyboard reset/self-test, lock-LED updates
// (only when PS2_KBD_LED_EN is defined), retries, and the scan-code decoder in IDLE.
module ps2_keyboard_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter logic [23:0] ACK_TIMEOUT = 24'd5_000_000,
  parameter logic [25:0] BAT_TIMEOUT = 26'd50_000_000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic [2:0] led_state,
  output logic       kbd_ready,
  output logic       kbd_error,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop
);

  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [25:0] ACK_LAST    = {2'b00, ACK_TIMEOUT} - 26'd1;
  localparam logic [25:0] BAT_LAST    = BAT_TIMEOUT - 26'd1;

  kbd_state_t  state;
  kbd_state_t  retry_state;
  cmd_kind_t   kind;
  logic        sent_ok;
  logic        retry_evt;
  logic [3:0]  retry_cnt;
  logic [25:0] timer;
  logic        idle;

`ifdef PS2_KBD_LED_EN
  logic [2:0] last_led;
  logic [2:0] led_arg;
`else
  logic unused_led;
  assign unused_led = ^led_state;
`endif

  assign idle = (state == ST_IDLE);

  // Every condition that costs a retry, and where the retry resumes.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    retry_evt   = 1'b0;
    retry_state = ST_SEND;
    case (state)
      ST_SEND: begin
        retry_evt   = !command_was_sent && error_communication_timed_out;
        retry_state = ST_DROP;
      end
      ST_WAIT_ACK:
        retry_evt = received_data_en ? (received_data == RSP_RESEND) : (timer >= ACK_LAST);
      ST_WAIT_BAT: begin
        retry_evt   = received_data_en ? (received_data == RSP_BAT_FAIL) : (timer >= BAT_LAST);
        retry_state = ST_INIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_INIT;
      kind         <= CMD_RESET;
      the_command  <= '0;
      send_command <= 1'b0;
      sent_ok      <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
      kbd_ready    <= 1'b0;
      kbd_error    <= 1'b0;
`ifdef PS2_KBD_LED_EN
      last_led     <= '0;
      led_arg      <= '0;
`endif
    end else if (retry_evt) begin
      send_command <= 1'b0;
      sent_ok      <= 1'b0;
      if (retry_cnt == RETRY_LIMIT) begin
        state     <= ST_FAIL;
        kbd_ready <= 1'b0;
        kbd_error <= 1'b1;
      end else begin
        retry_cnt <= retry_cnt + 4'd1;
        state     <= retry_state;
      end
    end else begin
      case (state)
        // A BAT-failure restart re-enters here, so the retry count is kept.
        ST_INIT: begin
          the_command <= CMD_RESET_KBD;
          kind        <= CMD_RESET;
          state       <= ST_SEND;
        end
        ST_SEND: begin
          if (command_was_sent) begin
            send_command <= 1'b0;
            sent_ok      <= 1'b1;
            state        <= ST_DROP;
          end else begin
            send_command <= 1'b1;
          end
        end
        ST_DROP: begin
          timer <= '0;
          state <= sent_ok ? ST_WAIT_ACK : ST_SEND;
        end
        ST_WAIT_ACK: begin
          if (received_data_en && received_data == RSP_ACK) begin
            case (kind)
              CMD_RESET: begin
                timer <= '0;
                state <= ST_WAIT_BAT;
              end
`ifdef PS2_KBD_LED_EN
              CMD_LED: begin
                the_command <= {5'b0, led_arg};
                kind        <= CMD_ARG;
                retry_cnt   <= '0;
                state       <= ST_SEND;
              end
              CMD_ARG: begin
                last_led <= led_arg;
                state    <= ST_IDLE;
              end
`endif
              default: state <= ST_IDLE;
            endcase
          end else begin
            timer <= timer + 26'd1;
          end
        end
        ST_WAIT_BAT: begin
          if (received_data_en && received_data == RSP_BAT_OK) begin
            kbd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer + 26'd1;
          end
        end
        ST_IDLE: begin
`ifdef PS2_KBD_LED_EN
          if (led_state != last_led) begin
            the_command <= CMD_SET_LED;
            led_arg     <= led_state;
            kind        <= CMD_LED;
            retry_cnt   <= '0;
            state       <= ST_SEND;
          end
`endif
        end
        default: send_command <= 1'b0;
      endcase
    end
  end

  ps2_scan_decoder u_decoder (
    .clk        (CLOCK_50),
    .rst_n      (resetn),
    .idle       (idle),
    .data       (received_data),
    .data_en    (received_data_en),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop)
  );

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Self-checking bench for ps2_keyboard_ctrl: host/keyboard behaviour driven from one thread,
// key events generated at event level and compared every cycle by a separate checker.
module tb_ps2_keyboard_ctrl;

  localparam logic [23:0] ACK_TO = 24'd100;
  localparam logic [25:0] BAT_TO = 26'd400;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic       kbd_ready, kbd_error;
  logic       key_valid, key_ext, key_break;
  logic [7:0] key_code;
  logic       key_left, key_right, key_down, key_rotate, key_drop;

  ps2_keyboard_ctrl #(
    .ACK_TIMEOUT (ACK_TO),
    .BAT_TIMEOUT (BAT_TO),
    .MAX_RETRY   (2)
  ) dut (
    .CLOCK_50                      (clk),
    .resetn                        (resetn),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .led_state                     (led_state),
    .kbd_ready                     (kbd_ready),
    .kbd_error                     (kbd_error),
    .key_valid                     (key_valid),
    .key_code                      (key_code),
    .key_ext                       (key_ext),
    .key_break                     (key_break),
    .key_left                      (key_left),
    .key_right                     (key_right),
    .key_down                      (key_down),
    .key_rotate                    (key_rotate),
    .key_drop                      (key_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    int         due;
  } ev_t;

  ev_t  exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_sends = 0;
  logic [7:0] drop_bytes [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Held-level rule: press of a listed key sets its level, release clears it.
  function automatic logic [4:0] apply_ev(input logic [4:0] lv, input ev_t e);
    logic [4:0] r;
    r = lv;
    if (e.ext) begin
      case (e.code)
        8'h6B: r[4] = !e.brk;
        8'h74: r[3] = !e.brk;
        8'h72: r[2] = !e.brk;
        8'h75: r[1] = !e.brk;
        default: ;
      endcase
    end else if (e.code == 8'h29) begin
      r[0] = !e.brk;
    end
    return r;
  endfunction

  // Per-cycle checker: events due this cycle, no stray events, held levels, stable command.
  initial begin
    logic [4:0] m_lv;
    logic       prev_send;
    logic [7:0] prev_cmd;
    ev_t        e;
    m_lv = '0;
    prev_send = 1'b0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_lv = '0;
        exp_q.delete();
        prev_send = 1'b0;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          check("ev_valid", 32'(key_valid), 1);
          check("ev_code", 32'(key_code), 32'(e.code));
          check("ev_ext", 32'(key_ext), 32'(e.ext));
          check("ev_break", 32'(key_break), 32'(e.brk));
          m_lv = apply_ev(m_lv, e);
        end else begin
          check("no_event", 32'(key_valid), 0);
        end
        check("levels", 32'({key_left, key_right, key_down, key_rotate, key_drop}), 32'(m_lv));
        if (send_command && prev_send)
          check("cmd_stable", 32'(the_command), 32'(prev_cmd));
        if (send_command && !prev_send)
          n_sends++;
        prev_send = send_command;
        prev_cmd = the_command;
      end
    end
  end

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    received_data = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic kbd_reply(input logic [7:0] b);
    repeat (2) @(negedge clk);
    strobe(b);
  endtask

  task automatic send_event(input logic [7:0] code, input logic ext, input logic brk);
    ev_t e;
    if (ext) strobe(8'hE0);
    if (brk) strobe(8'hF0);
    @(negedge clk);
    e.code = code;
    e.ext = ext;
    e.brk = brk;
    e.due = cyc + 1;
    exp_q.push_back(e);
    received_data = code;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (send_command) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_seen", 32'(ok), 1);
  endtask

  task automatic host_cmd(input logic [7:0] exp, input bit err);
    bit ok;
    wait_send(ok);
    check("cmd_byte", 32'(the_command), 32'(exp));
    repeat (2) @(negedge clk);
    if (err) error_communication_timed_out = 1'b1;
    else     command_was_sent = 1'b1;
    @(negedge clk);
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    check("send_fall", 32'(send_command), 0);
  endtask

  task automatic async_reset();
    #2 resetn = 1'b0;
    #1;
    check("rst_send", 32'(send_command), 0);
    check("rst_key_down", 32'(key_down), 0);
    check("rst_ready", 32'(kbd_ready), 0);
    @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic clean_init();
    host_cmd(8'hFF, 1'b0);
    kbd_reply(8'hFA);
    check("ready_before_bat", 32'(kbd_ready), 0);
    kbd_reply(8'hAA);
    check("ready_after_bat", 32'(kbd_ready), 1);
    check("no_error", 32'(kbd_error), 0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom);
    while (c inside {8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
    return c;
  endfunction

  initial begin
    int base;
    bit ok;
    logic [7:0] pause_tail [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] game_code [6]  = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h29};
    logic       game_ext  [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_send_command", 32'(send_command), 0);
    check("rst_the_command", 32'(the_command), 0);
    check("rst_kbd_ready", 32'(kbd_ready), 0);
    check("rst_kbd_error", 32'(kbd_error), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_key_ext", 32'(key_ext), 0);
    check("rst_key_break", 32'(key_break), 0);
    check("rst_levels", 32'({key_left, key_right, key_down, key_rotate, key_drop}), 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Clean init with stray prefix bytes during self-test wait
    base = n_sends;
    host_cmd(8'hFF, 1'b0);
    kbd_reply(8'hFA);
    strobe(8'hF0);
    strobe(8'hE0);
    check("ready_wait_bat", 32'(kbd_ready), 0);
    kbd_reply(8'hAA);
    check("init_ready", 32'(kbd_ready), 1);
    check("init_error", 32'(kbd_error), 0);
    check("init_one_ff", 32'(n_sends - base), 1);
    send_event(8'h1C, 1'b0, 1'b0);
    check("lit_1c_code", 32'(key_code), 'h1C);
    check("lit_1c_ext", 32'(key_ext), 0);

    // Extended press/release
    send_event(8'h6B, 1'b1, 1'b0);
    check("lit_left_valid", 32'(key_valid), 1);
    check("lit_left_ext", 32'(key_ext), 1);
    check("lit_left_brk", 32'(key_break), 0);
    check("lit_left_held", 32'(key_left), 1);
    repeat (3) @(negedge clk);
    check("lit_left_still", 32'(key_left), 1);
    send_event(8'h6B, 1'b1, 1'b1);
    check("lit_left_rel_brk", 32'(key_break), 1);
    check("lit_left_rel", 32'(key_left), 0);

    // Dropped byte clears a pending prefix; drop key ignores E0 29
    strobe(8'hE0);
    strobe(8'hFA);
    send_event(8'h29, 1'b0, 1'b0);
    check("lit_drop_ext", 32'(key_ext), 0);
    check("lit_drop_held", 32'(key_drop), 1);
    send_event(8'h29, 1'b1, 1'b1);
    check("lit_drop_ext_rel", 32'(key_drop), 1);
    send_event(8'h29, 1'b0, 1'b1);
    check("lit_drop_rel", 32'(key_drop), 0);

    // Pause sequence swallows seven bytes
    strobe(8'hE1);
    for (int i = 0; i < 7; i++) strobe(pause_tail[i]);
    send_event(8'h1C, 1'b0, 1'b0);
    check("lit_after_pause", 32'(key_code), 'h1C);

    // Randomized event stream
    for (int n = 0; n < 150; n++) begin
      int r, g;
      logic [7:0] c;
      logic x;
      r = $urandom_range(0, 7);
      if (r == 0) begin
        strobe(8'hE1);
        for (int i = 0; i < 7; i++) strobe(8'($urandom));
      end else if (r == 1) begin
        strobe(drop_bytes[$urandom_range(0, 5)]);
      end else if (r == 2) begin
        strobe(8'hE0);
        strobe(drop_bytes[$urandom_range(0, 5)]);
      end
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 5);
        c = game_code[g];
        x = game_ext[g];
      end else begin
        c = rand_code();
        x = 1'($urandom_range(0, 1));
      end
      send_event(c, x, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef PS2_KBD_LED_EN
    // LED update, with a second change during the argument transfer
    base = n_sends;
    led_state = 3'b101;
    host_cmd(8'hED, 1'b0);
    kbd_reply(8'hFA);
    led_state = 3'b011;
    host_cmd(8'h05, 1'b0);
    strobe(8'hE0);
    strobe(8'h1C);
    kbd_reply(8'hFA);
    host_cmd(8'hED, 1'b0);
    kbd_reply(8'hFA);
    host_cmd(8'h03, 1'b0);
    kbd_reply(8'hFA);
    repeat (40) @(negedge clk);
    check("led_send_count", 32'(n_sends - base), 4);
    send_event(8'h6B, 1'b0, 1'b0);
    check("lit_ext_not_leaked", 32'(key_ext), 0);
`else
    base = n_sends;
    led_state = 3'b101;
    repeat (60) @(negedge clk);
    check("led_disabled_no_send", 32'(n_sends - base), 0);
    led_state = 3'b000;
`endif

    // Reset mid-sequence with key_down held
    send_event(8'h72, 1'b1, 1'b0);
    check("down_held", 32'(key_down), 1);
`ifdef PS2_KBD_LED_EN
    led_state = 3'b110;
    wait_send(ok);
    check("led_cmd_in_flight", 32'(the_command), 'hED);
`endif
    async_reset();
    wait_send(ok);
    check("reinit_ff", 32'(the_command), 'hFF);
    async_reset();
    clean_init();
`ifdef PS2_KBD_LED_EN
    host_cmd(8'hED, 1'b0);
    kbd_reply(8'hFA);
    host_cmd(8'h06, 1'b0);
    kbd_reply(8'hFA);
    @(negedge clk);
    led_state = 3'b000;
`endif

    // Resend: send error then FE, both within the retry budget
    async_reset();
    host_cmd(8'hFF, 1'b1);
    host_cmd(8'hFF, 1'b0);
    kbd_reply(8'hFE);
    clean_init();

    // Self-test failure restarts the reset command
    async_reset();
    host_cmd(8'hFF, 1'b0);
    kbd_reply(8'hFA);
    kbd_reply(8'hFC);
    clean_init();

    // Exhaustion: silent keyboard
    async_reset();
    base = n_sends;
    host_cmd(8'hFF, 1'b0);
    host_cmd(8'hFF, 1'b0);
    check("no_error_mid_retry", 32'(kbd_error), 0);
    host_cmd(8'hFF, 1'b0);
    repeat (int'(ACK_TO) + 40) @(negedge clk);
    check("exhaust_error", 32'(kbd_error), 1);
    check("exhaust_ready", 32'(kbd_ready), 0);
    check("exhaust_attempts", 32'(n_sends - base), 3);
    check("exhaust_send_low", 32'(send_command), 0);

    repeat (5) @(negedge clk);
    check("events_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
